wb_slave_port_arbiter: RTL and testbench
========================================

// Module: wb_slave_port_arbiter
// PURPOSE
//  Per-slave-port controller for the NxN Wishbone interconnect: one instance per slave.
//  Arbitrates round-robin among N masters whose decoded cycles target this slave.
//  Locks the grant for the full CYC, drives the mux select for the shared slave datapath,
//  and aborts hung transfers with a watchdog ERR.
//  Datapath muxing stays in the interconnect; this block only sequences and selects.
// PARAMETERS
//  N_MASTERS       3    number of requesting masters (>=1)
//  TIMEOUT_CYCLES  256  cycles a strobe may wait for ACK/ERR; 0 disables watchdog
//  MID_W           $clog2(N_MASTERS) (min 1)  width of master id (localparam)
// PORTS
//  clk          in   1          clock; single clock domain
//  rstn         in   1          asynchronous, active-low reset
//  m_cyc        in   N_MASTERS  CYC of each master, already qualified by address decode for this slave
//  m_stb        in   N_MASTERS  STB of each master, decode-qualified
//  s_ack        in   1          ACK from slave
//  s_err        in   1          ERR from slave
//  gnt          out  N_MASTERS  one-hot grant; drives master-side ACK/ERR/DAT_R routing
//  gnt_id       out  MID_W      binary index of granted master; valid when gnt_vld
//  gnt_vld      out  1          a master owns the slave
//  s_gate       out  1          1 = mux forces slave CYC/STB low (idle or abort)
//  to_err       out  N_MASTERS  one-cycle synthesized ERR to the owning master on watchdog expiry
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, rstn=0)
//   - gnt=0, gnt_id=0, gnt_vld=0, s_gate=1, to_err=0, busy=0.
//   - State IDLE, rr_ptr=0, wd_cnt=0.
//   - Reset mid-transfer drops grant immediately; there is no recovery handshake.
//  States: IDLE, OWN, ABORT (typedef arb_state_e).
//  IDLE
//   - req = m_cyc & m_stb.
//   - If req!=0: pick first set bit scanning from rr_ptr upward with wrap.
//   - Registered outputs at next edge: gnt=onehot(pick), gnt_id=pick, gnt_vld=1, s_gate=0, wd_cnt=0.
//   - Go to OWN. Latency is one cycle from req to gnt.
//  OWN
//   - Grant held while m_cyc[gnt_id]=1; other requests are ignored (bus lock for bursts and RMW).
//   - When m_cyc[gnt_id]=0:
//     - Next edge: gnt=0, gnt_vld=0, s_gate=1, rr_ptr=(gnt_id+1) mod N_MASTERS.
//     - Go to IDLE. One dead cycle follows before the next grant.
//  Watchdog (OWN only, TIMEOUT_CYCLES>0)
//   - wd_cnt increments each cycle m_stb[gnt_id]=1 and s_ack=0 and s_err=0.
//   - wd_cnt clears on s_ack or s_err, or when m_stb[gnt_id]=0.
//   - wd_cnt saturates; its width is $clog2(TIMEOUT_CYCLES+1).
//   - When wd_cnt==TIMEOUT_CYCLES-1 and the strobe is still unanswered:
//     - Next edge: to_err[gnt_id]=1 for exactly one cycle, s_gate=1.
//     - Go to ABORT.
//   - ACK/ERR arriving in the same cycle as expiry wins: no to_err, counter clears.
//  ABORT
//   - gnt is held so the master sees to_err, s_gate=1; slave ACK/ERR are ignored.
//   - Leave on m_cyc[gnt_id]=0 with the same release actions as OWN.
//  Boundaries
//   - Requester drops CYC in the same cycle it is granted: release on the next edge, rr_ptr advances.
//   - N_MASTERS=1: rr_ptr is constant 0.
//   - All outputs are registered; no combinational path from inputs to gnt/s_gate.
// STRUCTURE
//  - wb_arb_pkg: arb_state_e, function rr_next(ptr,N).
//  - Sub-module wb_rr_pick: combinational rotating priority encoder with inputs req and ptr,
//    outputs pick and any. Parameterized by N.
//  - Top: state register, rr_ptr, wd_cnt, output registers.
// TESTING (N_MASTERS=3, TIMEOUT_CYCLES=8 unless stated)
//  1. Reset
//     - Stimulus: rstn low, then release with no requests.
//     - Required: gnt=0, s_gate=1, busy=0 held.
//  2. Round-robin fairness
//     - Stimulus: m0,m1,m2 request continuously, each single-beat (CYC drop after ACK).
//     - Required: grants in order 0,1,2,0.
//     - Required: exactly one dead cycle between grants; no grant overlap.
//  3. Burst lock
//     - Stimulus: m1 holds CYC for 4 ACKed beats while m0 requests.
//     - Required: gnt=3'b010 throughout; m0 granted the cycle after m1 drops CYC + 1 dead cycle.
//  4. Watchdog
//     - Stimulus: m2 strobes, slave never ACKs.
//     - Required: to_err=3'b100 for 1 cycle, 9 cycles after grant (1 grant + 8 wait).
//     - Required: s_gate=1; release only after m2 drops CYC.
//  5. Race
//     - Stimulus: s_ack on the same cycle wd_cnt==7.
//     - Required: no to_err, wd_cnt=0, state stays OWN.
//  6. Async reset mid-burst
//     - Stimulus: rstn pulsed low mid-cycle while in OWN.
//     - Required: gnt=0, s_gate=1 immediately.
//     - Required: after reset, first grant goes to lowest requesting index (rr_ptr=0).

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone slave-port arbiter.
package wb_arb_pkg;

  // Arbiter states: no owner, owner in a live cycle, owner being aborted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  // Round-robin successor of ptr among n requesters (wraps to 0).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (n <= 1) begin
      return 0;
    end
    if (ptr >= n - 1) begin
      return 0;
    end
    return ptr + 1;
  endfunction

  // (a + b) mod n, used to map a rotated scan position back to a master index.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    if (n == 0) begin
      return 0;
    end
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, with wrap.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N   = 3,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] pick,
  output logic           any
);

  // Two copies of req shifted down by ptr put the scan start at bit 0.
  logic [2*N-1:0] w_rot;

  assign w_rot = {req, req} >> ptr;

  // Scan the rotated vector from bit 0; the first hit wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && w_rot[k]) begin
        any  = 1'b1;
        pick = IDW'(wrap_add(32'(ptr), 32'(k), 32'(N)));
      end
    end
  end

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// Per-slave-port controller: round-robin grant among decode-qualified masters,
// grant locked for the whole CYC, and a watchdog that aborts unanswered strobes.
//
// Handshake: a master requests with CYC&STB; once granted it owns the slave until
// it drops CYC. A strobe is answered by s_ack or s_err in the cycle they are high;
// a strobe left unanswered for TIMEOUT_CYCLES cycles is answered instead by a
// one-cycle to_err pulse to the owner while the slave side is gated off.
module wb_slave_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_MASTERS      = 3,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int MID_W          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int WD_W           = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] m_cyc,
  input  logic [N_MASTERS-1:0] m_stb,
  input  logic                 s_ack,
  input  logic                 s_err,
  output logic [N_MASTERS-1:0] gnt,
  output logic [MID_W-1:0]     gnt_id,
  output logic                 gnt_vld,
  output logic                 s_gate,
  output logic [N_MASTERS-1:0] to_err,
  output logic                 busy,
  output arb_state_e           dbg_state,
  output logic [WD_W-1:0]      dbg_wd_cnt,
  output logic [MID_W-1:0]     dbg_rr_ptr
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  arb_state_e           r_state;
  logic [MID_W-1:0]     r_rr_ptr;
  logic [WD_W-1:0]      r_wd_cnt;
  logic [N_MASTERS-1:0] r_gnt;
  logic [MID_W-1:0]     r_gnt_id;
  logic                 r_gnt_vld;
  logic                 r_s_gate;
  logic [N_MASTERS-1:0] r_to_err;

  arb_state_e           w_state_nxt;
  logic [MID_W-1:0]     w_rr_ptr_nxt;
  logic [WD_W-1:0]      w_wd_cnt_nxt;
  logic [N_MASTERS-1:0] w_gnt_nxt;
  logic [MID_W-1:0]     w_gnt_id_nxt;
  logic                 w_gnt_vld_nxt;
  logic                 w_s_gate_nxt;
  logic [N_MASTERS-1:0] w_to_err_nxt;

  logic [N_MASTERS-1:0] w_req;
  logic [MID_W-1:0]     w_pick;
  logic                 w_any;
  logic                 w_own_cyc;
  logic                 w_own_stb;
  logic                 w_answered;

  assign w_req = m_cyc & m_stb;

  // r_gnt is one-hot while a master owns the slave, so masking picks its signals.
  assign w_own_cyc  = |(m_cyc & r_gnt);
  assign w_own_stb  = |(m_stb & r_gnt);
  assign w_answered = s_ack | s_err;

  wb_rr_pick #(
    .N   (N_MASTERS),
    .IDW (MID_W)
  ) u_pick (
    .req  (w_req),
    .ptr  (r_rr_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  // Next-state and next-output decode; every register holds unless a branch says otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = r_gnt_vld;
    w_s_gate_nxt  = r_s_gate;
    w_to_err_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt     = N_MASTERS'(1) << w_pick;
          w_gnt_id_nxt  = w_pick;
          w_gnt_vld_nxt = 1'b1;
          w_s_gate_nxt  = 1'b0;
          w_wd_cnt_nxt  = '0;
          w_state_nxt   = OWN;
        end
      end

      OWN: begin
        if (!w_own_cyc) begin
          // Owner ended its cycle: free the slave and move priority past it.
          w_gnt_nxt     = '0;
          w_gnt_vld_nxt = 1'b0;
          w_s_gate_nxt  = 1'b1;
          w_rr_ptr_nxt  = MID_W'(rr_next(32'(r_gnt_id), 32'(N_MASTERS)));
          w_wd_cnt_nxt  = '0;
          w_state_nxt   = IDLE;
        end else if (w_answered || !w_own_stb) begin
          // A response (even on the expiry cycle) or an idle strobe restarts the wait.
          w_wd_cnt_nxt = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (r_wd_cnt == WD_LAST) begin
            w_to_err_nxt = r_gnt;
            w_s_gate_nxt = 1'b1;
            w_wd_cnt_nxt = '0;
            w_state_nxt  = ABORT;
          end else if (r_wd_cnt != WD_MAX) begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
          end
        end
      end

      ABORT: begin
        // Grant stays so the owner can route to_err; slave responses are ignored.
        if (!w_own_cyc) begin
          w_gnt_nxt     = '0;
          w_gnt_vld_nxt = 1'b0;
          w_s_gate_nxt  = 1'b1;
          w_rr_ptr_nxt  = MID_W'(rr_next(32'(r_gnt_id), 32'(N_MASTERS)));
          w_wd_cnt_nxt  = '0;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_gnt_nxt     = '0;
        w_gnt_vld_nxt = 1'b0;
        w_s_gate_nxt  = 1'b1;
        w_wd_cnt_nxt  = '0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_wd_cnt  <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_s_gate  <= 1'b1;
      r_to_err  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_s_gate  <= w_s_gate_nxt;
      r_to_err  <= w_to_err_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign gnt_id     = r_gnt_id;
  assign gnt_vld    = r_gnt_vld;
  assign s_gate     = r_s_gate;
  assign to_err     = r_to_err;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;
  assign dbg_wd_cnt = r_wd_cnt;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_wb_slave_port_arbiter.sv
// Bench for wb_slave_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against an ownership-level model of the arbiter.
module tb_wb_slave_port_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int T  = 8;
  localparam int MW = 2;
  localparam int WW = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  m_cyc = '0;
  logic [N-1:0]  m_stb = '0;
  logic          s_ack = 1'b0;
  logic          s_err = 1'b0;
  logic [N-1:0]  gnt;
  logic [MW-1:0] gnt_id;
  logic          gnt_vld;
  logic          s_gate;
  logic [N-1:0]  to_err;
  logic          busy;
  arb_state_e    dbg_state;
  logic [WW-1:0] dbg_wd_cnt;
  logic [MW-1:0] dbg_rr_ptr;

  wb_slave_port_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m_cyc      (m_cyc),
    .m_stb      (m_stb),
    .s_ack      (s_ack),
    .s_err      (s_err),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_vld    (gnt_vld),
    .s_gate     (s_gate),
    .to_err     (to_err),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_wd_cnt (dbg_wd_cnt),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic [MW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who owns the slave (-1 = nobody), whether the owner was aborted,
  // how long its strobe has waited, and where the next round-robin scan starts.
  int mo_owner = -1;
  bit mo_abort = 1'b0;
  int mo_wait  = 0;
  int mo_next  = 0;
  int mo_te    = -1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mo_owner = -1;
      mo_abort = 1'b0;
      mo_wait  = 0;
      mo_next  = 0;
      mo_te    = -1;
    end else begin
      mo_te = -1;
      if (mo_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mo_next + k) % N;
          if (mo_owner < 0 && m_cyc[c] && m_stb[c]) mo_owner = c;
        end
        mo_wait  = 0;
        mo_abort = 1'b0;
      end else if (!m_cyc[mo_owner]) begin
        mo_next  = (mo_owner + 1) % N;
        mo_owner = -1;
        mo_abort = 1'b0;
        mo_wait  = 0;
      end else if (!mo_abort) begin
        if (s_ack || s_err || !m_stb[mo_owner]) begin
          mo_wait = 0;
        end else if (mo_wait == T - 1) begin
          mo_te    = mo_owner;
          mo_abort = 1'b1;
          mo_wait  = 0;
        end else begin
          mo_wait++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] eg;
      logic [N-1:0] et;
      arb_state_e   est;
      eg  = (mo_owner >= 0) ? (N'(1) << mo_owner) : '0;
      et  = (mo_te >= 0) ? (N'(1) << mo_te) : '0;
      est = (mo_owner < 0) ? IDLE : (mo_abort ? ABORT : OWN);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_vld", 32'(gnt_vld), 32'(mo_owner >= 0));
      if (mo_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(mo_owner));
      chk("s_gate", 32'(s_gate), 32'((mo_owner < 0) || mo_abort));
      chk("busy", 32'(busy), 32'(mo_owner >= 0));
      chk("to_err", 32'(to_err), 32'(et));
      chk("state", 32'(dbg_state), 32'(est));
      chk("wd_cnt", 32'(dbg_wd_cnt), 32'(mo_wait));
      chk("rr_ptr", 32'(dbg_rr_ptr), 32'(mo_next));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    s_ack = 1'b0;
    s_err = 1'b0;
    m_cyc = '0;
    m_stb = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_got;
    int gap;
    int cnt;
    bit seen;
    bit prev_vld;
    logic [N-1:0] acked;

    // 1. Reset
    rstn = 1'b0;
    step();
    chk_en = 1'b1;
    chk("reset_gnt", 32'(gnt), 32'(0));
    chk("reset_s_gate", 32'(s_gate), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'(0));
      chk("idle_s_gate", 32'(s_gate), 32'(1));
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // 2. Round-robin fairness with single-beat transfers
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
    n_got = 0;
    gap = 0;
    prev_vld = 1'b0;
    acked = '0;
    for (int c = 0; c < 60 && n_got < 4; c++) begin
      if (gnt_vld && !prev_vld) begin
        if (n_got > 0) chk("rr_dead_cycles", 32'(gap), 32'(1));
        if (exp_q.size() > 0) chk("rr_order", 32'(gnt_id), 32'(exp_q.pop_front()));
        n_got++;
        gap = 0;
      end else if (!gnt_vld) begin
        gap++;
      end
      prev_vld = gnt_vld;
      s_ack = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (gnt_vld && gnt[i]) begin
          if (!acked[i]) begin
            s_ack = 1'b1;
            acked[i] = 1'b1;
          end else begin
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
          end
        end else if (!m_cyc[i]) begin
          m_cyc[i] = 1'b1;
          m_stb[i] = 1'b1;
          acked[i] = 1'b0;
        end
      end
      step();
    end
    chk("rr_grants_seen", 32'(n_got), 32'(4));
    m_cyc[2:1] = 2'b00;
    m_stb[2:1] = 2'b00;
    idle_bus();
    step();
    step();

    // 3. Burst lock: m1 holds CYC over 4 beats while m0 waits
    m_cyc = 3'b011;
    m_stb = 3'b011;
    step();
    chk("burst_grant", 32'(gnt), 32'(3'b010));
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      step();
      chk("burst_lock", 32'(gnt), 32'(3'b010));
    end
    s_ack = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    step();
    chk("burst_dead_cycle", 32'(gnt), 32'(3'b000));
    step();
    chk("burst_next_m0", 32'(gnt), 32'(3'b001));
    s_ack = 1'b1;
    step();
    idle_bus();
    step();
    step();

    // 4. Watchdog: m2 strobes, slave never answers
    m_cyc = 3'b100;
    m_stb = 3'b100;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      cnt++;
      if (to_err != '0) seen = 1'b1;
    end
    chk("wd_latency", 32'(cnt), 32'(9));
    chk("wd_to_err", 32'(to_err), 32'(3'b100));
    chk("wd_s_gate", 32'(s_gate), 32'(1));
    step();
    chk("wd_pulse_width", 32'(to_err), 32'(0));
    chk("abort_hold_gnt", 32'(gnt), 32'(3'b100));
    chk("abort_state", 32'(dbg_state), 32'(ABORT));
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    chk("abort_ignores_ack", 32'(dbg_state), 32'(ABORT));
    chk("abort_s_gate", 32'(s_gate), 32'(1));
    idle_bus();
    step();
    chk("abort_release_gnt", 32'(gnt), 32'(0));
    chk("abort_release_busy", 32'(busy), 32'(0));
    step();

    // 5. Race: ACK arrives on the expiry cycle
    m_cyc = 3'b001;
    m_stb = 3'b001;
    step();
    chk("race_grant", 32'(gnt), 32'(3'b001));
    repeat (7) step();
    chk("race_wd_pre", 32'(dbg_wd_cnt), 32'(7));
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    chk("race_no_to_err", 32'(to_err), 32'(0));
    chk("race_wd_clear", 32'(dbg_wd_cnt), 32'(0));
    chk("race_state", 32'(dbg_state), 32'(OWN));
    repeat (2) step();
    chk("race_still_own", 32'(dbg_state), 32'(OWN));
    idle_bus();
    step();
    step();

    // 6. Async reset mid-burst, with the pointer parked away from 0
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step();
    s_ack = 1'b1;
    step();
    idle_bus();
    step();
    step();
    m_cyc = 3'b111;
    m_stb = 3'b111;
    step();
    chk("pre_reset_grant", 32'(gnt), 32'(3'b100));
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'(0));
    chk("async_rst_s_gate", 32'(s_gate), 32'(1));
    chk("async_rst_vld", 32'(gnt_vld), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    #2 rstn = 1'b1;
    step();
    chk("post_reset_grant", 32'(gnt), 32'(3'b001));
    idle_bus();
    step();
    step();

    // 7. Random traffic; alternate windows with a responsive and a silent slave
    for (int c = 0; c < 900; c++) begin
      int ack_pct;
      ack_pct = (((c / 100) % 2) == 0) ? 35 : 0;
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
          end else begin
            m_stb[i] = ($urandom_range(0, 7) != 0);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[i] = 1'b1;
          m_stb[i] = ($urandom_range(0, 3) != 0);
        end
      end
      s_ack = ($urandom_range(0, 99) < ack_pct);
      s_err = !s_ack && ($urandom_range(0, 99) < 4);
      step();
    end
    idle_bus();
    repeat (3) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
